spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_slave.sv | 124 ++++++++++++
 tb/tb_spi_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI defaults and state encoding
package spi_pkg;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchronizer with rise/fall detection
module spi_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{IDLE_LEVEL}};
            dly   <= IDLE_LEVEL;
        end else begin
            chain <= STAGES'({chain, din});
            dly   <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~dly;
    assign fall = ~chain[STAGES-1] & dly;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 slave, MSB first, with multi-frame bursts
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    spi_state_t             state, state_d;
    logic [DATA_WIDTH-1:0]  tx_sr, tx_d;
    logic [DATA_WIDTH-1:0]  rx_sr, rx_d;
    logic [DATA_WIDTH-1:0]  dout_d;
    logic [CNT_W-1:0]       bit_cnt, cnt_d;
    logic                   miso_q, miso_d;
    logic                   nd_d;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // tx_sr holds the bits still to be presented; miso_q is the bit on the wire.
    // A completion reload puts the whole next word in tx_sr so the following
    // sck fall presents its MSB without a stray shift.
    always_comb begin
        state_d = state;
        tx_d    = tx_sr;
        rx_d    = rx_sr;
        cnt_d   = bit_cnt;
        miso_d  = miso_q;
        dout_d  = data_out;
        nd_d    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    tx_d    = data_in << 1;
                    miso_d  = data_in[DATA_WIDTH-1];
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    rx_d = {rx_sr[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt == LAST_BIT) begin
                        dout_d = rx_d;
                        nd_d   = 1'b1;
                        tx_d   = data_in;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = bit_cnt + 1'b1;
                    end
                end else if (sck_fall) begin
                    miso_d = tx_sr[DATA_WIDTH-1];
                    tx_d   = tx_sr << 1;
                end
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            data_out  <= '0;
            new_data  <= 1'b0;
            mosi_sync <= '0;
        end else begin
            state     <= state_d;
            tx_sr     <= tx_d;
            rx_sr     <= rx_d;
            bit_cnt   <= cnt_d;
            miso_q    <= miso_d;
            data_out  <= dout_d;
            new_data  <= nd_d;
            mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
        end
    end

    assign busy    = (state == SHIFT);
    assign miso_oe = busy;
    assign miso    = miso_q & miso_oe;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       new_data;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         nd_count = 0;
    int         nd_cyc   = 0;
    int         rise_cyc = 0;
    int         din_chg_at = -1;
    int         base;
    logic [7:0] din_next;
    logic [7:0] nd_hist [0:31];
    logic [15:0] mi;

    always #5 clk = ~clk;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .data_in  (data_in),
        .data_out (data_out),
        .new_data (new_data),
        .busy     (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_data === 1'b1) begin
            if (nd_count < 32) nd_hist[nd_count] = data_out;
            nd_count = nd_count + 1;
            nd_cyc   = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ss_select();
        ss_n = 1'b0;
        wait_clk(H);
    endtask

    task automatic ss_release();
        wait_clk(H);
        ss_n = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic shift_bits(input logic [15:0] mo, input int nbits, output logic [15:0] mi_o);
        mi_o = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == din_chg_at) data_in = din_next;
            mosi = mo[nbits-1-i];
            wait_clk(H);
            mi_o = {mi_o[14:0], miso};
            sck = 1'b1;
            rise_cyc = cyc;
            wait_clk(H);
            sck = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; data_in = 8'h00;
        wait_clk(1); ss_n = 1'b0; sck = 1'b1;
        wait_clk(1); sck = 1'b0;
        wait_clk(1); ss_n = 1'b1; sck = 1'b1;
        wait_clk(1); sck = 1'b0;
        check_eq("rst_miso", miso, 1'b0);
        check_eq("rst_miso_oe", miso_oe, 1'b0);
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_new_data", new_data, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        rst = 1'b1;
        wait_clk(4);

        // single frame
        data_in = 8'h54;
        base = nd_count;
        ss_select();
        check_eq("single_busy", busy, 1'b1);
        check_eq("single_miso_oe", miso_oe, 1'b1);
        shift_bits(16'h00A5, 8, mi);
        check_eq("single_nd_count", nd_count - base, 1);
        check_eq("single_data_out", data_out, 8'hA5);
        check_eq("single_miso_rx", mi[7:0], 8'h54);
        check_eq("single_latency", nd_cyc - rise_cyc, 3);
        ss_release();
        check_eq("single_end_busy", busy, 1'b0);
        check_eq("single_end_miso_oe", miso_oe, 1'b0);
        check_eq("single_end_miso", miso, 1'b0);

        // abort after 5 bits
        data_in = 8'h11;
        base = nd_count;
        ss_select();
        shift_bits(16'h001F, 5, mi);
        ss_release();
        check_eq("abort_nd_count", nd_count - base, 0);
        check_eq("abort_data_out", data_out, 8'hA5);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_miso_oe", miso_oe, 1'b0);

        // two-frame burst with data_in changed mid-frame
        data_in = 8'h54;
        din_next = 8'h52;
        din_chg_at = 4;
        base = nd_count;
        ss_select();
        shift_bits(16'h3CC3, 16, mi);
        din_chg_at = -1;
        ss_release();
        check_eq("burst_nd_count", nd_count - base, 2);
        check_eq("burst_first", nd_hist[base], 8'h3C);
        check_eq("burst_second", nd_hist[base+1], 8'hC3);
        check_eq("burst_data_out", data_out, 8'hC3);
        check_eq("burst_miso_rx", mi, 16'h5452);

        // reset mid-frame
        data_in = 8'h99;
        ss_select();
        shift_bits(16'h0004, 3, mi);
        rst = 1'b0;
        #1;
        check_eq("midrst_data_out", data_out, 8'h00);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_miso_oe", miso_oe, 1'b0);
        check_eq("midrst_miso", miso, 1'b0);
        ss_n = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(4);
        check_eq("midrst_idle_busy", busy, 1'b0);
        data_in = 8'h3A;
        base = nd_count;
        ss_select();
        shift_bits(16'h0081, 8, mi);
        ss_release();
        check_eq("postrst_nd_count", nd_count - base, 1);
        check_eq("postrst_data_out", data_out, 8'h81);
        check_eq("postrst_miso_rx", mi[7:0], 8'h3A);

        // ss_n rise coincident with the final sck rise
        data_in = 8'hE7;
        base = nd_count;
        ss_select();
        shift_bits(16'h0035, 7, mi);
        mosi = 1'b1;
        wait_clk(H);
        ss_n = 1'b1;
        sck  = 1'b1;
        wait_clk(H);
        sck = 1'b0;
        wait_clk(H);
        check_eq("coinc_nd_count", nd_count - base, 1);
        check_eq("coinc_data_out", data_out, 8'h6B);
        check_eq("coinc_miso_rx", mi[6:0], 7'h73);
        check_eq("coinc_busy", busy, 1'b0);
        check_eq("coinc_miso_oe", miso_oe, 1'b0);

        // sck activity while deselected is ignored
        for (int k = 0; k < 8; k++) begin
            mosi = 1'b0;
            sck = 1'b1;
            wait_clk(H);
            sck = 1'b0;
            wait_clk(H);
        end
        check_eq("idle_sck_nd_count", nd_count - base, 1);
        check_eq("idle_sck_data_out", data_out, 8'h6B);
        check_eq("idle_sck_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
